// File: rtl/accum_32bit_pkg.sv
// Shared definitions for the 32-bit beat accumulator: datapath widths and
// the two-state control encoding.
package accum_32bit_pkg;

  localparam int DATA_W = 32;
  localparam int SUM_W  = 64;

  typedef enum logic {
    ACC  = 1'b0,
    HOLD = 1'b1
  } state_t;

endpackage

// File: rtl/adder_32bit.sv
// Plain 32-bit ripple/adder primitive with carry out; the low accumulator
// word is built on this block.
module adder_32bit (
  input  logic [31:0] a,
  input  logic [31:0] b,
  output logic [31:0] s,
  output logic        c32
);

  assign {c32, s} = {1'b0, a} + {1'b0, b};

endmodule

// File: rtl/accum_32bit.sv
// Accumulates a group of 32-bit beats into a 64-bit sum with a saturating
// beat counter; the result is held until the consumer handshakes it.
module accum_32bit
  import accum_32bit_pkg::*;
#(
  parameter int CNT_W = 8
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [DATA_W-1:0]  in_data,
  input  logic               in_last,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [SUM_W-1:0]   out_sum,
  output logic [CNT_W-1:0]   out_count,
  output logic               out_cnt_sat
);

  state_t              state, state_nxt;
  logic [DATA_W-1:0]   acc_lo, acc_hi;
  logic [DATA_W-1:0]   lo_sum;
  logic                lo_carry;
  logic [CNT_W-1:0]    cnt;
  logic                cnt_sat;
  logic                accept;
  logic                drain;

  adder_32bit u_adder (
    .a   (acc_lo),
    .b   (in_data),
    .s   (lo_sum),
    .c32 (lo_carry)
  );

  assign accept = in_valid && in_ready;
  assign drain  = out_valid && out_ready;

  // NOTE: every output of a combinational block is given a default first so
  // no path leaves it unassigned and a latch cannot be inferred.
  always_comb begin
    state_nxt = state;
    in_ready  = 1'b0;
    out_valid = 1'b0;
    case (state)
      ACC: begin
        in_ready = 1'b1;
        if (accept && in_last) state_nxt = HOLD;
      end
      HOLD: begin
        out_valid = 1'b1;
        if (drain) state_nxt = ACC;
      end
      default: state_nxt = ACC;
    endcase
  end

  // NOTE: state registers use non-blocking assignments so every flop samples
  // the pre-edge values regardless of statement order.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= ACC;
      acc_lo  <= '0;
      acc_hi  <= '0;
      cnt     <= '0;
      cnt_sat <= 1'b0;
    end else begin
      state <= state_nxt;
      if (drain) begin
        acc_lo  <= '0;
        acc_hi  <= '0;
        cnt     <= '0;
        cnt_sat <= 1'b0;
      end else if (accept) begin
        acc_lo <= lo_sum;
        acc_hi <= acc_hi + DATA_W'(lo_carry);
        // Counter sticks at all-ones; a beat arriving there flags saturation.
        if (&cnt) cnt_sat <= 1'b1;
        else      cnt     <= cnt + 1'b1;
      end
    end
  end

  assign out_sum     = {acc_hi, acc_lo};
  assign out_count   = cnt;
  assign out_cnt_sat = cnt_sat;

endmodule
